kicker_ctrl: RTL
================

# kicker_ctrl

Parametrised multi-channel kicker controller for the robot's solenoid kick path (flat and chip coils). It manages capacitor charge enable and accepts one-shot kick requests with a selectable strength level. It fires one coil for a level-derived pulse width, then enforces a recharge cooldown. It sits between the command decoder and the charger/coil driver pins, and optionally gates firing on the ball-presence IR breakbeam.

## Interface
Parameters:
- NUM_CH, 2, number of coil channels (0 = flat, 1 = chip).
- LEVEL_W, 3, width of kick strength level.
- CNT_W, 24, width of the shared down-counter.
- BASE_W, 100000, pulse width in cycles for level 1 minus STEP_W.
- STEP_W, 50000, extra pulse cycles per level step.
- COOL_CYCLES, 500000, charge-inhibit cycles after a kick.
- ARM_TIMEOUT, 5000000, maximum wait for IR in ARMED.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- kick_req  in  1  single-cycle kick request strobe.
- kick_ch  in  $clog2(NUM_CH)  coil select, sampled with kick_req.
- kick_level  in  LEVEL_W  strength, sampled with kick_req; 0 is invalid.
- ir  in  1  asynchronous breakbeam, high = ball present.
- cap_full  in  1  charger reports capacitor at target voltage.
- charge  out  1  charger enable.
- trigger  out  NUM_CH  one-hot coil fire.
- busy  out  1  high in any state other than IDLE.
- kick_done  out  1  one-cycle pulse, kick completed.
- kick_reject  out  1  one-cycle pulse, request refused or timed out.

## Operation
- All outputs are registered. Reset values: charge=0, trigger=0, busy=0, kick_done=0, kick_reject=0. State is IDLE and the counter is 0.
- ir passes through a 2-flop synchroniser (ir_s). The synchroniser is cleared by rst.
- IDLE: charge=1. A request is accepted when kick_req=1, kick_level≠0, kick_ch<NUM_CH and cap_full=1.
  - On accept, load counter=BASE_W+kick_level*STEP_W. Compute this in CNT_W bits with no truncation (the design constraint is that the maximum level fits). Latch the channel.
  - Next state is FIRE, or ARMED when the macro is defined.
  - A request failing any condition gives kick_reject the next cycle and the block stays in IDLE.
- ARMED (macro only): charge=1, trigger=0.
  - If ir_s=1, go to FIRE with the latched width.
  - If ARM_TIMEOUT cycles elapse first, pulse kick_reject and return to IDLE.
- FIRE: charge=0. trigger[ch]=1, all other bits 0. The counter decrements each cycle. After exactly W trigger-high cycles, go to COOLDOWN.
- COOLDOWN: charge=0, trigger=0, counter=COOL_CYCLES. kick_done pulses on the first COOLDOWN cycle. At count end, go to IDLE, and charge returns the same cycle.
- kick_req while busy=1 is ignored and produces a kick_reject pulse. It never re-triggers or extends a pulse.
- trigger is never multi-hot. trigger and charge are never both high.
- rst in any state, including mid-FIRE, drops trigger and charge on the same edge.

## Timing
- Request at edge N (no macro): trigger high on cycles N+1 … N+W. kick_done at N+W+1. charge high again at N+W+1+COOL_CYCLES.
- With the macro: trigger starts on the cycle after the first ARMED cycle with ir_s=1. The minimum accept-to-trigger latency is 2 cycles. The raw-ir-to-trigger latency is 3 cycles.
- kick_reject occurs 1 cycle after the offending kick_req.
- Back-to-back kicks are separated by at least W+COOL_CYCLES+1 cycles.

## Configuration
- KICKER_IR_GATE_EN
  - Defined: the ARMED state exists, firing waits for ir_s, and the ARM_TIMEOUT abort is active.
  - Undefined: ARMED is removed, ir is unused (synchroniser optimised away), and accept goes straight to FIRE.

## Structure
- Package kicker_pkg holds:
  - the state enum (IDLE, ARMED, FIRE, COOLDOWN);
  - channel constants CH_FLAT=0 and CH_CHIP=1;
  - the width function level→cycles, shared with the bench model.
- Sub-module kicker_timer: a loadable CNT_W down-counter with load and done. It is shared by FIRE, COOLDOWN and ARMED.

## Test plan
Bench parameters: BASE_W=4, STEP_W=2, COOL_CYCLES=3, ARM_TIMEOUT=10.
- Reset: hold rst 3 cycles mid-FIRE → trigger=0 and charge=0 on the next edge. After release, charge=1 one cycle later.
- No macro; kick_req with ch=1, level=3, cap_full=1 at N → trigger=2'b10 on N+1…N+10, kick_done at N+11, charge=1 at N+14.
- Rejects: level=0, cap_full=0, or kick_req during FIRE → one kick_reject pulse each. The trigger sequence in progress is unchanged.
- Macro; ir held 0 → after 10 ARMED cycles kick_reject pulses, the block is back in IDLE and trigger never rises.
- Macro; ir rises 5 cycles after accept → trigger begins 3 cycles after the ir edge, and width is exact for ch=0, level=7 (18 cycles).
- Random requests and ir over 10k cycles → assertions that trigger is one-hot-or-zero, !(charge && |trigger), and there is at most one kick_done per accept.

Source files
------------

// File: rtl/kicker_pkg.sv
// kicker_pkg: FSM state type, coil channel ids and the level-to-pulse-width rule
// shared by the controller and its bench model.
package kicker_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } kick_state_e;

  localparam int CH_FLAT = 0;
  localparam int CH_CHIP = 1;

  // Pulse width in cycles for a strength level; level 0 is never accepted.
  function automatic int unsigned kick_width(input int unsigned base_w,
                                             input int unsigned step_w,
                                             input int unsigned level);
    return base_w + level * step_w;
  endfunction

endpackage

// File: rtl/kicker_timer.sv
// kicker_timer: loadable down-counter shared by the ARMED timeout, FIRE width
// and COOLDOWN phases. done marks the last cycle of a loaded interval.
module kicker_timer
  import kicker_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  // A load of N gives done on the Nth cycle after the load edge.
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/kicker_ctrl.sv
// kicker_ctrl: solenoid kicker sequencer (charge, fire one coil, cool down).
// Define KICKER_IR_GATE_EN to hold accepted kicks in ARMED until the breakbeam sees the ball.
module kicker_ctrl
  import kicker_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int LEVEL_W     = 3,
  parameter  int CNT_W       = 24,
  parameter  int BASE_W      = 100000,
  parameter  int STEP_W      = 50000,
  parameter  int COOL_CYCLES = 500000,
  parameter  int ARM_TIMEOUT = 5000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kick_req,
  input  logic [CH_W-1:0]    kick_ch,
  input  logic [LEVEL_W-1:0] kick_level,
  input  logic               ir,
  input  logic               cap_full,
  output logic               charge,
  output logic [NUM_CH-1:0]  trigger,
  output logic               busy,
  output logic               kick_done,
  output logic               kick_reject
);

  kick_state_e state, nstate;

  logic [CH_W-1:0]        ch_q, ch_nxt;
  logic [CNT_W-1:0]       req_w, load_val;
  logic                   load, t_done, req_ok, reject;
  logic [NUM_CH-1:0]      fire_oh;
  logic [(1<<CH_W)-1:0]   ch_valid;

  assign req_w = CNT_W'(kick_width(BASE_W, STEP_W, 32'(kick_level)));

  // Codes at or above NUM_CH name no coil and are refused.
  always_comb begin
    for (int i = 0; i < (1 << CH_W); i++) ch_valid[i] = (i < NUM_CH);
  end

`ifdef KICKER_IR_GATE_EN
  logic             ir_m, ir_s;
  logic [CNT_W-1:0] w_q, w_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_m <= 1'b0;
      ir_s <= 1'b0;
      w_q  <= '0;
    end else begin
      ir_m <= ir;
      ir_s <= ir_m;
      w_q  <= w_nxt;
    end
  end
`else
  logic unused_ir;
  assign unused_ir = ir;
`endif

  kicker_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (t_done)
  );

  always_comb begin
    nstate   = state;
    ch_nxt   = ch_q;
    load     = 1'b0;
    load_val = '0;
    reject   = 1'b0;
`ifdef KICKER_IR_GATE_EN
    w_nxt    = w_q;
`endif
    req_ok   = (kick_level != '0) && ch_valid[kick_ch] && cap_full;
    case (state)
      IDLE: begin
        if (kick_req) begin
          if (req_ok) begin
            ch_nxt = kick_ch;
            load   = 1'b1;
`ifdef KICKER_IR_GATE_EN
            nstate   = ARMED;
            load_val = CNT_W'(ARM_TIMEOUT);
            w_nxt    = req_w;
`else
            nstate   = FIRE;
            load_val = req_w;
`endif
          end else begin
            reject = 1'b1;
          end
        end
      end
`ifdef KICKER_IR_GATE_EN
      ARMED: begin
        reject = kick_req;
        // Ball sighting wins over a timeout landing on the same cycle.
        if (ir_s) begin
          nstate   = FIRE;
          load     = 1'b1;
          load_val = w_q;
        end else if (t_done) begin
          nstate = IDLE;
          reject = 1'b1;
        end
      end
`endif
      FIRE: begin
        reject = kick_req;
        if (t_done) begin
          nstate   = COOLDOWN;
          load     = 1'b1;
          load_val = CNT_W'(COOL_CYCLES);
        end
      end
      COOLDOWN: begin
        reject = kick_req;
        if (t_done) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) fire_oh[i] = (ch_nxt == CH_W'(i));
  end

  // Outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch_q        <= '0;
      charge      <= 1'b0;
      trigger     <= '0;
      busy        <= 1'b0;
      kick_done   <= 1'b0;
      kick_reject <= 1'b0;
    end else begin
      state       <= nstate;
      ch_q        <= ch_nxt;
      charge      <= (nstate == IDLE) || (nstate == ARMED);
      trigger     <= (nstate == FIRE) ? fire_oh : '0;
      busy        <= (nstate != IDLE);
      kick_done   <= (state == FIRE) && (nstate == COOLDOWN);
      kick_reject <= reject;
    end
  end

endmodule
